// File: rtl/maxpool_reader.sv
// rtl/maxpool_reader.sv - 2x2 stride-2 max-pool engine reading a conv map and writing the pooled map
//
// Purpose:
//   Walks an H_IN x W_IN signed feature map two rows at a time. Port A reads the
//   even row of each 2x2 window, port B the odd row. Each window takes two read
//   cycles (left column, then right column) and produces one write. Pooled
//   values are written in raster order to addresses 0..(W_IN/2)*(H_IN/2)-1.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   start      one-cycle request, honoured only while idle
//   busy       run in progress (low in the done cycle)
//   done       one-cycle pulse the cycle after the final write
//   rd_addr_a  port-A read address (even row of window)
//   rd_addr_b  port-B read address (odd row of window)
//   rd_en_a    port-A read enable
//   rd_en_b    port-B read enable
//   q_a, q_b   read data, valid one cycle after the address
//   wr_addr    pooled-map write address
//   wr_data    pooled value
//   wr_en      write enable, one pulse per pooled output
//
// Build option:
//   MAXPOOL_RELU_EN  when defined, negative pooled values are written as 0.

module maxpool_reader #(
    parameter int W_IN   = 24,
    parameter int H_IN   = 24,
    parameter int DW     = 16,
    parameter int AW_IN  = 10,
    parameter int AW_OUT = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [AW_IN-1:0]     rd_addr_a,
    output logic [AW_IN-1:0]     rd_addr_b,
    output logic                 rd_en_a,
    output logic                 rd_en_b,
    input  logic signed [DW-1:0] q_a,
    input  logic signed [DW-1:0] q_b,
    output logic [AW_OUT-1:0]    wr_addr,
    output logic signed [DW-1:0] wr_data,
    output logic                 wr_en
);

    localparam int RW = $clog2(H_IN / 2 + 1);
    localparam int CW = $clog2(W_IN / 2 + 1);
    localparam logic [RW-1:0] R_LAST = RW'(H_IN / 2 - 1);
    localparam logic [CW-1:0] C_LAST = CW'(W_IN / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [RW-1:0]         r_row;
    logic [CW-1:0]         r_col;
    logic                  r_phase;
    logic [AW_IN-1:0]      r_rd_addr_a;
    logic [AW_IN-1:0]      r_rd_addr_b;
    logic                  r_rd_en;
    logic                  r_qv;        // q_a/q_b carry data this cycle
    logic                  r_qp;        // phase (column) of that data
    logic signed [DW-1:0]  r_m0;        // running max of the window's left column
    logic [AW_OUT-1:0]     r_out_idx;
    logic [AW_OUT-1:0]     r_wr_addr;
    logic signed [DW-1:0]  r_wr_data;
    logic                  r_wr_en;

    logic                  w_wrap;
    logic                  w_last_read;
    logic signed [DW-1:0]  w_pair_max;
    logic signed [DW-1:0]  w_win_max;
    logic signed [DW-1:0]  w_pool;

    function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    always_comb begin
        w_wrap      = r_phase && (r_col == C_LAST);
        w_last_read = (r_state == S_READ) && w_wrap && (r_row == R_LAST);
        w_pair_max  = smax(q_a, q_b);
        w_win_max   = smax(r_m0, w_pair_max);
`ifdef MAXPOOL_RELU_EN
        w_pool      = w_win_max[DW-1] ? '0 : w_win_max;
`else
        w_pool      = w_win_max;
`endif
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_READ;
            S_READ:  if (w_last_read) w_next_state = S_DRAIN;
            // The final write is on the outputs this cycle; done follows it.
            S_DRAIN: if (r_wr_en) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_row       <= '0;
            r_col       <= '0;
            r_phase     <= 1'b0;
            r_rd_addr_a <= '0;
            r_rd_addr_b <= '0;
            r_rd_en     <= 1'b0;
            r_qv        <= 1'b0;
            r_qp        <= 1'b0;
            r_m0        <= '0;
            r_out_idx   <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_wr_en     <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_row       <= '0;
                r_col       <= '0;
                r_phase     <= 1'b0;
                r_rd_addr_a <= '0;
                r_rd_addr_b <= AW_IN'(W_IN);
                r_rd_en     <= 1'b1;
                r_out_idx   <= '0;
            end else if (r_state == S_READ) begin
                r_phase <= ~r_phase;
                if (w_last_read) begin
                    r_rd_en <= 1'b0;
                end else if (w_wrap) begin
                    // Skip the odd row already covered by port B.
                    r_col       <= '0;
                    r_row       <= r_row + RW'(1);
                    r_rd_addr_a <= r_rd_addr_a + AW_IN'(W_IN + 1);
                    r_rd_addr_b <= r_rd_addr_b + AW_IN'(W_IN + 1);
                end else begin
                    if (r_phase) r_col <= r_col + CW'(1);
                    r_rd_addr_a <= r_rd_addr_a + AW_IN'(1);
                    r_rd_addr_b <= r_rd_addr_b + AW_IN'(1);
                end
            end

            r_qv    <= r_rd_en;
            r_qp    <= r_phase;
            r_wr_en <= r_qv && r_qp;
            if (r_qv && !r_qp) r_m0 <= w_pair_max;
            if (r_qv && r_qp) begin
                r_wr_data <= w_pool;
                r_wr_addr <= r_out_idx;
                r_out_idx <= r_out_idx + AW_OUT'(1);
            end
        end
    end

    assign busy      = (r_state == S_READ) || (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);
    assign rd_addr_a = r_rd_addr_a;
    assign rd_addr_b = r_rd_addr_b;
    assign rd_en_a   = r_rd_en;
    assign rd_en_b   = r_rd_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign wr_en     = r_wr_en;

endmodule

// File: tb/tb_maxpool_reader.sv
// tb/tb_maxpool_reader.sv - self-checking bench for maxpool_reader (4x4 and 24x24 instances)

module tb_maxpool_reader;

    logic clk = 1'b0;
    logic reset_n;
    logic start_s, start_b;
    bit   sel;           // 0 = 4x4 instance, 1 = 24x24 instance
    int   cur_w, cur_h;

    logic busy_s, done_s, rea_s, reb_s, wen_s;
    logic [3:0] ra_s, rb_s;
    logic [1:0] wa_s;
    logic signed [15:0] wd_s, qa_s, qb_s;

    logic busy_b, done_b, rea_b, reb_b, wen_b;
    logic [9:0] ra_b, rb_b;
    logic [7:0] wa_b;
    logic signed [15:0] wd_b, qa_b, qb_b;

    logic signed [15:0] mem_s [16];
    logic signed [15:0] mem_b [1024];

    logic o_busy, o_done, o_rea, o_reb, o_wen;
    logic [15:0] o_ra, o_rb, o_wa;
    logic signed [15:0] o_wd;

    int exp_v [144];
    int got_v [144];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    maxpool_reader #(.W_IN(4), .H_IN(4), .DW(16), .AW_IN(4), .AW_OUT(2)) u_small (
        .clk(clk), .reset_n(reset_n), .start(start_s), .busy(busy_s), .done(done_s),
        .rd_addr_a(ra_s), .rd_addr_b(rb_s), .rd_en_a(rea_s), .rd_en_b(reb_s),
        .q_a(qa_s), .q_b(qb_s), .wr_addr(wa_s), .wr_data(wd_s), .wr_en(wen_s));

    maxpool_reader u_big (
        .clk(clk), .reset_n(reset_n), .start(start_b), .busy(busy_b), .done(done_b),
        .rd_addr_a(ra_b), .rd_addr_b(rb_b), .rd_en_a(rea_b), .rd_en_b(reb_b),
        .q_a(qa_b), .q_b(qb_b), .wr_addr(wa_b), .wr_data(wd_b), .wr_en(wen_b));

    always @(posedge clk) begin
        if (rea_s) qa_s <= mem_s[ra_s];
        if (reb_s) qb_s <= mem_s[rb_s];
        if (rea_b) qa_b <= mem_b[ra_b];
        if (reb_b) qb_b <= mem_b[rb_b];
    end

    always_comb begin
        if (sel) begin
            o_busy = busy_b; o_done = done_b; o_rea = rea_b; o_reb = reb_b; o_wen = wen_b;
            o_ra = 16'(ra_b); o_rb = 16'(rb_b); o_wa = 16'(wa_b); o_wd = wd_b;
        end else begin
            o_busy = busy_s; o_done = done_s; o_rea = rea_s; o_reb = reb_s; o_wen = wen_s;
            o_ra = 16'(ra_s); o_rb = 16'(rb_s); o_wa = 16'(wa_s); o_wd = wd_s;
        end
    end

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start_b = v;
        else     start_s = v;
    endtask

    function automatic int rd_mem(input int idx);
        if (sel) return int'(mem_b[idx]);
        return int'(mem_s[idx]);
    endfunction

    // Reference: plain 2x2 max over the stored map, raster order.
    function automatic void build_model();
        int best, v, j;
        j = 0;
        for (int wr = 0; wr < cur_h / 2; wr++) begin
            for (int wc = 0; wc < cur_w / 2; wc++) begin
                best = -100000;
                for (int dy = 0; dy < 2; dy++)
                    for (int dx = 0; dx < 2; dx++) begin
                        v = rd_mem((2 * wr + dy) * cur_w + 2 * wc + dx);
                        if (v > best) best = v;
                    end
`ifdef MAXPOOL_RELU_EN
                if (best < 0) best = 0;
`endif
                exp_v[j] = best;
                j++;
            end
        end
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, int'(o_busy), 0);
        chk({tag, "_done"}, int'(o_done), 0);
        chk({tag, "_rd_en_a"}, int'(o_rea), 0);
        chk({tag, "_rd_en_b"}, int'(o_reb), 0);
        chk({tag, "_wr_en"}, int'(o_wen), 0);
        chk({tag, "_rd_addr_a"}, int'(o_ra), 0);
        chk({tag, "_rd_addr_b"}, int'(o_rb), 0);
        chk({tag, "_wr_addr"}, int'(o_wa), 0);
        chk({tag, "_wr_data"}, int'(o_wd), 0);
    endtask

    // Pulses start, then checks every output on every cycle against the
    // timeline derived from the window count n: reads k=0..2n-1, write j at
    // k=3+2j, done at k=2n+2 (k = edges after the start edge).
    task automatic run_map(input bit repulse, input int rst_after, output int done_k, output int nw);
        int n, w, p, r, c, ea, j;
        bit stop, ew;
        n = (cur_w / 2) * (cur_h / 2);
        done_k = -1; nw = 0; stop = 0;
        build_model();
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        for (int k = 0; k <= 2 * n + 4 && !stop; k++) begin
            chk("busy", int'(o_busy), int'(k <= 2 * n + 1));
            chk("done", int'(o_done), int'(k == 2 * n + 2));
            chk("rd_en_a", int'(o_rea), int'(k < 2 * n));
            chk("rd_en_b", int'(o_reb), int'(k < 2 * n));
            if (k < 2 * n) begin
                w = k / 2; p = k % 2; r = w / (cur_w / 2); c = w % (cur_w / 2);
                ea = 2 * r * cur_w + 2 * c + p;
                chk("rd_addr_a", int'(o_ra), ea);
                chk("rd_addr_b", int'(o_rb), ea + cur_w);
            end
            ew = (k >= 3) && (k <= 2 * n + 1) && ((k - 3) % 2 == 0);
            chk("wr_en", int'(o_wen), int'(ew));
            if (ew) begin
                j = (k - 3) / 2;
                chk("wr_addr", int'(o_wa), j);
                chk("wr_data", int'(o_wd), exp_v[j]);
            end
            if (o_done && done_k < 0) done_k = k;
            if (o_wen) begin
                if (nw < 144) got_v[nw] = int'(o_wd);
                nw++;
            end
            if (rst_after > 0 && nw == rst_after) begin
                stop = 1;
                reset_n = 1'b0;
                @(posedge clk); #1;
                reset_n = 1'b1;
                chk_all_zero("midrst");
                for (int m = 0; m < 8; m++) begin
                    @(posedge clk); #1;
                    chk("postrst_done", int'(o_done), 0);
                    chk("postrst_wr_en", int'(o_wen), 0);
                    chk("postrst_busy", int'(o_busy), 0);
                end
            end else begin
                set_start(repulse && (k == 2 || k == 10));
                @(posedge clk); #1;
            end
        end
        set_start(1'b0);
    endtask

    initial begin
        int dk, nw, offs[4];
        reset_n = 1'b0; start_s = 1'b0; start_b = 1'b0; sel = 0;
        cur_w = 4; cur_h = 4;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        sel = 0; #1; chk_all_zero("rst_small");
        sel = 1; #1; chk_all_zero("rst_big");
        @(posedge clk); #1;

        // value = address
        sel = 0; cur_w = 4; cur_h = 4;
        for (int i = 0; i < 16; i++) mem_s[i] = 16'(i);
        run_map(0, 0, dk, nw);
        chk("A_done_k", dk, 10);
        chk("A_writes", nw, 4);
        chk("A_w0", got_v[0], 5);
        chk("A_w1", got_v[1], 7);
        chk("A_w2", got_v[2], 13);
        chk("A_w3", got_v[3], 15);

        // all negative
        for (int i = 0; i < 16; i++) mem_s[i] = 16'(-100 - i);
        run_map(0, 0, dk, nw);
        chk("B_writes", nw, 4);
`ifdef MAXPOOL_RELU_EN
        chk("B_w0", got_v[0], 0);
        chk("B_w1", got_v[1], 0);
        chk("B_w2", got_v[2], 0);
        chk("B_w3", got_v[3], 0);
`else
        chk("B_w0", got_v[0], -100);
        chk("B_w1", got_v[1], -102);
        chk("B_w2", got_v[2], -108);
        chk("B_w3", got_v[3], -110);
`endif

        // 24x24 random, plain and with start re-pulsed mid-run
        sel = 1; cur_w = 24; cur_h = 24;
        for (int i = 0; i < 1024; i++) mem_b[i] = 16'($urandom);
        run_map(0, 0, dk, nw);
        chk("C_done_k", dk, 290);
        chk("C_writes", nw, 144);
        for (int i = 0; i < 576; i++) mem_b[i] = 16'($urandom);
        run_map(1, 0, dk, nw);
        chk("C2_done_k", dk, 290);
        chk("C2_writes", nw, 144);

        // 4x4 with start re-pulsed during READ and in the DONE cycle
        sel = 0; cur_w = 4; cur_h = 4;
        for (int i = 0; i < 16; i++) mem_s[i] = 16'($urandom);
        run_map(1, 0, dk, nw);
        chk("D_done_k", dk, 10);
        chk("D_writes", nw, 4);

        // reset after the second write, then a clean run
        for (int i = 0; i < 16; i++) mem_s[i] = 16'($urandom);
        run_map(0, 2, dk, nw);
        chk("E_no_done", dk, -1);
        chk("E_writes_before_rst", nw, 2);
        run_map(0, 0, dk, nw);
        chk("E2_done_k", dk, 10);
        chk("E2_writes", nw, 4);

        // max at each window position in turn
        offs[0] = 0; offs[1] = 1; offs[2] = 4; offs[3] = 5;
        for (int pos = 0; pos < 4; pos++) begin
            for (int i = 0; i < 16; i++) mem_s[i] = 16'(int'($urandom_range(2000, 0)) - 1000);
            for (int wr = 0; wr < 2; wr++)
                for (int wc = 0; wc < 2; wc++)
                    mem_s[8 * wr + 2 * wc + offs[pos]] = 16'(20000 + 2 * wr + wc);
            run_map(0, 0, dk, nw);
            chk("F_w0", got_v[0], 20000);
            chk("F_w3", got_v[3], 20003);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
